// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes and FSM states.
package mdu_pkg;

    localparam int unsigned OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        MDU_NOP   = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL      = 2'd1,
        ST_DIV_ITER = 2'd2,
        ST_DIV_FIX  = 2'd3
    } mdu_state_e;

endpackage

// File: rtl/mdu_if.sv
// Execute-stage handshake between pipeline control and the multiply/divide unit.
interface mdu_if
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
);

    logic             op_valid;
    logic [OP_W-1:0]  op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output op_valid, op, a, b, flush,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  op_valid, op, a, b, flush,
        output busy, done, div_by_zero, hi, lo
    );

endinterface

// File: rtl/mdu_div_core.sv
// Unsigned iterative restoring divider: one quotient bit per clock, WIDTH steps per divide.
module mdu_div_core #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             valid
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_q, run_d;
    logic             valid_q, valid_d;
    logic [WIDTH:0]   partial_c;
    logic [WIDTH:0]   diff_c;

    // Quotient register doubles as the dividend shifter; its MSB feeds the partial remainder.
    always_comb begin
        rem_d     = rem_q;
        quot_d    = quot_q;
        dvsr_d    = dvsr_q;
        cnt_d     = cnt_q;
        run_d     = run_q;
        valid_d   = valid_q;
        partial_c = {rem_q, quot_q[WIDTH-1]};
        diff_c    = partial_c - {1'b0, dvsr_q};

        if (abort) begin
            run_d   = 1'b0;
            valid_d = 1'b0;
        end else if (start) begin
            rem_d   = '0;
            quot_d  = dividend;
            dvsr_d  = divisor;
            cnt_d   = CNT_W'(WIDTH);
            run_d   = 1'b1;
            valid_d = 1'b0;
        end else if (run_q) begin
            if (diff_c[WIDTH]) begin
                rem_d  = partial_c[WIDTH-1:0];
                quot_d = {quot_q[WIDTH-2:0], 1'b0};
            end else begin
                rem_d  = diff_c[WIDTH-1:0];
                quot_d = {quot_q[WIDTH-2:0], 1'b1};
            end
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                run_d   = 1'b0;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rem_q   <= '0;
            quot_q  <= '0;
            dvsr_q  <= '0;
            cnt_q   <= '0;
            run_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            rem_q   <= rem_d;
            quot_q  <= quot_d;
            dvsr_q  <= dvsr_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
            valid_q <= valid_d;
        end
    end

    assign quot  = quot_q;
    assign rem   = rem_q;
    assign valid = valid_q;

endmodule

// File: rtl/mdu.sv
// MIPS multiply/divide unit owning HI/LO: pipelined-latency multiply, iterative divide, flushable.
module mdu
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MUL_CYCLES = 4
) (
    input  logic clk,
    input  logic resetn,
    mdu_if.slave bus
);

    localparam int unsigned PROD_W  = 2 * WIDTH;
    localparam int unsigned CNT_MAX = (MUL_CYCLES > WIDTH) ? MUL_CYCLES : WIDTH;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    mdu_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PROD_W-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic [WIDTH-1:0]  lo_q, lo_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              dbz_q, dbz_d;
    logic              qneg_q, qneg_d;
    logic              rneg_q, rneg_d;
    logic              zero_q, zero_d;

    logic              accept_c;
    logic              signed_op_c;
    logic              sign_a_c, sign_b_c;
    logic [PROD_W-1:0] mul_a_c, mul_b_c, prod_c;
    logic [WIDTH-1:0]  dvd_c, dvs_c;
    logic              div_start_c;
    logic [WIDTH-1:0]  div_quot, div_rem;
    logic              div_valid;

    // Operand conditioning: sign-extend for the product, take magnitudes for the divider.
    always_comb begin
        signed_op_c = (bus.op == MDU_MULT) || (bus.op == MDU_DIV);
        sign_a_c    = signed_op_c && bus.a[WIDTH-1];
        sign_b_c    = signed_op_c && bus.b[WIDTH-1];
        mul_a_c     = {{WIDTH{sign_a_c}}, bus.a};
        mul_b_c     = {{WIDTH{sign_b_c}}, bus.b};
        prod_c      = mul_a_c * mul_b_c;
        dvd_c       = sign_a_c ? (~bus.a + WIDTH'(1)) : bus.a;
        dvs_c       = sign_b_c ? (~bus.b + WIDTH'(1)) : bus.b;
        accept_c    = bus.op_valid && !busy_q && !bus.flush;
    end

    mdu_div_core #(
        .WIDTH (WIDTH)
    ) u_div_core (
        .clk      (clk),
        .resetn   (resetn),
        .start    (div_start_c),
        .abort    (bus.flush),
        .dividend (dvd_c),
        .divisor  (dvs_c),
        .quot     (div_quot),
        .rem      (div_rem),
        .valid    (div_valid)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        prod_d      = prod_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        done_d      = 1'b0;
        dbz_d       = 1'b0;
        qneg_d      = qneg_q;
        rneg_d      = rneg_q;
        zero_d      = zero_q;
        div_start_c = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    case (bus.op)
                        MDU_MULT, MDU_MULTU: begin
                            prod_d  = prod_c;
                            cnt_d   = CNT_W'(MUL_CYCLES - 1);
                            state_d = ST_MUL;
                        end
                        MDU_DIV, MDU_DIVU: begin
                            qneg_d = sign_a_c ^ sign_b_c;
                            rneg_d = sign_a_c;
                            if (bus.b == '0) begin
                                // Zero divisor skips the iterations and reports from the fix-up cycle.
                                zero_d  = 1'b1;
                                state_d = ST_DIV_FIX;
                            end else begin
                                zero_d      = 1'b0;
                                div_start_c = 1'b1;
                                cnt_d       = CNT_W'(WIDTH - 1);
                                state_d     = ST_DIV_ITER;
                            end
                        end
                        MDU_MTHI: hi_d = bus.a;
                        MDU_MTLO: lo_d = bus.a;
                        default: ;
                    endcase
                end
            end
            ST_MUL: begin
                if (cnt_q == '0) begin
                    hi_d    = prod_q[PROD_W-1:WIDTH];
                    lo_d    = prod_q[WIDTH-1:0];
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DIV_ITER: begin
                if (cnt_q == '0) begin
                    state_d = ST_DIV_FIX;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DIV_FIX: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                if (zero_q) begin
                    dbz_d = 1'b1;
                end else if (div_valid) begin
                    lo_d = qneg_q ? (~div_quot + WIDTH'(1)) : div_quot;
                    hi_d = rneg_q ? (~div_rem + WIDTH'(1)) : div_rem;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Flush beats any completion landing on the same edge.
        if (bus.flush) begin
            state_d = ST_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
            done_d  = 1'b0;
            dbz_d   = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            prod_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            zero_q  <= zero_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed corner cases plus random ops against an arithmetic model.
module tb_mdu;

    localparam int unsigned W    = 32;
    localparam int unsigned MULC = 4;
    localparam int unsigned DIVL = W + 1;

    logic clk;
    logic resetn;

    mdu_if #(.WIDTH(W)) bus ();

    mdu #(
        .WIDTH      (W),
        .MUL_CYCLES (MULC)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (bus.busy === 1'b1 && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return W'($urandom_range(0, 20));
            default: return $urandom();
        endcase
    endfunction

    // Model: results from plain arithmetic, latency from the documented completion edges.
    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] e_hi, e_lo;
        logic [63:0]  p;
        longint       sa, sb, q, r;
        bit           e_dbz, e_long;
        int           e_lat, cyc;
        e_hi   = m_hi;
        e_lo   = m_lo;
        e_dbz  = 1'b0;
        e_long = 1'b0;
        e_lat  = 0;
        sa     = longint'($signed(a));
        sb     = longint'($signed(b));
        case (op)
            3'd1: begin p = 64'(sa * sb); e_hi = p[63:32]; e_lo = p[31:0]; e_long = 1; e_lat = MULC; end
            3'd2: begin p = 64'(a) * 64'(b); e_hi = p[63:32]; e_lo = p[31:0]; e_long = 1; e_lat = MULC; end
            3'd3: begin
                e_long = 1;
                if (b == '0) begin e_dbz = 1; e_lat = 1; end
                else begin q = sa / sb; r = sa % sb; e_lo = q[31:0]; e_hi = r[31:0]; e_lat = DIVL; end
            end
            3'd4: begin
                e_long = 1;
                if (b == '0) begin e_dbz = 1; e_lat = 1; end
                else begin e_lo = a / b; e_hi = a % b; e_lat = DIVL; end
            end
            3'd5: e_hi = a;
            3'd6: e_lo = a;
            default: ;
        endcase

        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.op       = op;
        bus.a        = a;
        bus.b        = b;
        @(posedge clk);
        #1;
        bus.op_valid = 1'b0;

        if (!e_long) begin
            check($sformatf("op%0d busy", op), 64'(bus.busy), 64'(0));
            check($sformatf("op%0d done", op), 64'(bus.done), 64'(0));
            check($sformatf("op%0d hi", op), 64'(bus.hi), 64'(e_hi));
            check($sformatf("op%0d lo", op), 64'(bus.lo), 64'(e_lo));
        end else begin
            check($sformatf("op%0d busy_after_accept", op), 64'(bus.busy), 64'(1));
            wait_idle(cyc);
            check($sformatf("op%0d latency", op), 64'(cyc), 64'(e_lat));
            check($sformatf("op%0d done", op), 64'(bus.done), 64'(1));
            check($sformatf("op%0d dbz", op), 64'(bus.div_by_zero), 64'(e_dbz));
            check($sformatf("op%0d hi a=%0h b=%0h", op, a, b), 64'(bus.hi), 64'(e_hi));
            check($sformatf("op%0d lo a=%0h b=%0h", op, a, b), 64'(bus.lo), 64'(e_lo));
            @(posedge clk);
            #1;
            check($sformatf("op%0d done_one_cycle", op), 64'(bus.done), 64'(0));
        end
        m_hi = e_hi;
        m_lo = e_lo;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        int ndone;
        logic [2:0] rop;

        resetn       = 1'b0;
        bus.op_valid = 1'b0;
        bus.op       = '0;
        bus.a        = '0;
        bus.b        = '0;
        bus.flush    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset hi", 64'(bus.hi), 64'(0));
        check("reset lo", 64'(bus.lo), 64'(0));
        check("reset busy", 64'(bus.busy), 64'(0));
        check("reset done", 64'(bus.done), 64'(0));
        check("reset dbz", 64'(bus.div_by_zero), 64'(0));
        resetn = 1'b1;

        // Directed cases from the test plan.
        run_op(3'd1, 32'hFFFF_FFFF, 32'h2);
        run_op(3'd2, 32'hFFFF_FFFF, 32'h2);
        run_op(3'd3, 32'hFFFF_FFF9, 32'h2);
        run_op(3'd4, 32'd100, 32'd7);
        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(3'd5, 32'h11, 32'h0);
        run_op(3'd6, 32'h22, 32'h0);
        run_op(3'd4, 32'h1234, 32'h0);
        run_op(3'd5, 32'hDEAD_BEEF, 32'h0);
        run_op(3'd6, 32'h1234_5678, 32'h0);
        run_op(3'd7, 32'hAAAA_AAAA, 32'h5);
        run_op(3'd0, 32'h5555_5555, 32'h5);

        // Flush a DIVU in its 10th cycle.
        @(negedge clk);
        bus.op_valid = 1'b1; bus.op = 3'd4; bus.a = 32'd1000; bus.b = 32'd3;
        @(posedge clk);
        #1;
        bus.op_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        check("flush busy", 64'(bus.busy), 64'(0));
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            ndone += int'(bus.done);
            @(posedge clk);
            #1;
        end
        check("flush no_done", 64'(ndone), 64'(0));
        check("flush hi", 64'(bus.hi), 64'(m_hi));
        check("flush lo", 64'(bus.lo), 64'(m_lo));

        // Flush on the multiply completion edge wins.
        @(negedge clk);
        bus.op_valid = 1'b1; bus.op = 3'd2; bus.a = 32'd9; bus.b = 32'd9;
        @(posedge clk);
        #1;
        bus.op_valid = 1'b0;
        repeat (MULC - 1) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        check("flush_at_done done", 64'(bus.done), 64'(0));
        check("flush_at_done busy", 64'(bus.busy), 64'(0));
        check("flush_at_done lo", 64'(bus.lo), 64'(m_lo));

        // Flush in IDLE blocks acceptance.
        @(negedge clk);
        bus.op_valid = 1'b1; bus.op = 3'd5; bus.a = 32'hCAFE_F00D; bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.op_valid = 1'b0; bus.flush = 1'b0;
        check("flush_idle hi", 64'(bus.hi), 64'(m_hi));

        // MULT presented while a DIVU is busy is ignored.
        @(negedge clk);
        bus.op_valid = 1'b1; bus.op = 3'd4; bus.a = 32'd100; bus.b = 32'd7;
        @(posedge clk);
        #1;
        bus.op = 3'd1; bus.a = 32'h0000_1234; bus.b = 32'h0000_5678;
        repeat (5) @(posedge clk);
        #1;
        bus.op_valid = 1'b0;
        wait_idle(cyc);
        check("ignore latency", 64'(cyc + 5), 64'(DIVL));
        check("ignore lo", 64'(bus.lo), 64'(14));
        check("ignore hi", 64'(bus.hi), 64'(2));
        m_hi = 32'd2;
        m_lo = 32'd14;
        ndone = 0;
        for (int i = 0; i < int'(MULC) + 3; i++) begin
            @(posedge clk);
            #1;
            ndone += int'(bus.done);
        end
        check("ignore no_extra_done", 64'(ndone), 64'(0));

        // Randomized ops against the model.
        for (int i = 0; i < 60; i++) begin
            rop = 3'($urandom_range(0, 7));
            run_op(rop, pick(), pick());
        end

        // Reset in the middle of a multiply discards it.
        @(negedge clk);
        bus.op_valid = 1'b1; bus.op = 3'd1; bus.a = 32'h7; bus.b = 32'h9;
        @(posedge clk);
        #1;
        bus.op_valid = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        check("midreset hi", 64'(bus.hi), 64'(0));
        check("midreset lo", 64'(bus.lo), 64'(0));
        check("midreset busy", 64'(bus.busy), 64'(0));
        check("midreset done", 64'(bus.done), 64'(0));
        check("midreset dbz", 64'(bus.div_by_zero), 64'(0));
        m_hi = '0;
        m_lo = '0;
        ndone = 0;
        for (int i = 0; i < int'(MULC) + 3; i++) begin
            @(posedge clk);
            #1;
            ndone += int'(bus.done);
        end
        check("midreset no_done", 64'(ndone), 64'(0));
        check("midreset lo_after", 64'(bus.lo), 64'(0));

        run_op(3'd3, 32'hFFFF_FFF9, 32'h2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mdu.md
# mdu

Parametrised multi-cycle multiply/divide unit that owns the HI/LO register pair for the MIPS datapath. It sits beside the ALU in the execute stage and handles MULT, MULTU, DIV, DIVU, MTHI and MTLO. Long operations raise `busy` so the pipeline control logic can stall. Multiply latency is configurable, division uses an iterative restoring divider, and an in-flight operation can be flushed.

## Interface
Parameters:
- `WIDTH`, 32: operand width. HI and LO are each `WIDTH` bits. Must be ≥ 4 and even.
- `MUL_CYCLES`, 4: cycles from accept to HI/LO write for MULT/MULTU. Must be ≥ 1.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `resetn`  in  1  synchronous, active-low reset.
- `op_valid`  in  1  an operation is presented this cycle.
- `op`  in  3  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; 7 is treated as NOP.
- `a`  in  WIDTH  rs operand (dividend / multiplicand / MTHI/MTLO source).
- `b`  in  WIDTH  rt operand (divisor / multiplier).
- `flush`  in  1  abort the in-flight operation.
- `busy`  out  1  a multi-cycle operation is in progress.
- `done`  out  1  one-cycle pulse: MULT/MULTU/DIV/DIVU completed.
- `div_by_zero`  out  1  valid with `done`: the divide had `b == 0`.
- `hi`  out  WIDTH  current HI register.
- `lo`  out  WIDTH  current LO register.

## Operation
- States: `IDLE`, `MUL`, `DIV_ITER`, `DIV_FIX`.
- Accept condition: `op_valid && !busy && !flush`. While `busy` is high, `op_valid` is ignored.
- MTHI / MTLO:
  - `hi`/`lo` is set to `a` at the accept edge.
  - No busy cycle and no `done` pulse.
- MULT / MULTU:
  - The full 2·WIDTH product is computed, signed or unsigned.
  - The product is held in a `MUL_CYCLES`-deep countdown.
  - On completion, `{hi,lo}` ← product and `done` pulses.
- DIV / DIVU:
  - Operand magnitudes are latched (absolute value for signed ops).
  - `WIDTH` restoring iterations produce one quotient bit each.
  - `DIV_FIX` applies signs:
    - The quotient is negated if the operand signs differ.
    - The remainder takes the dividend's sign.
  - Writes `lo` ← quotient, `hi` ← remainder, and pulses `done`.
  - Most-negative ÷ −1 wraps: quotient = most-negative, remainder 0. No flag is raised.
- Divide by zero:
  - No iteration is performed and HI/LO are unchanged.
  - `done` and `div_by_zero` pulse one cycle after accept.
- Flush:
  - Any state returns to `IDLE` at the next edge.
  - HI/LO are unchanged and no `done` pulse occurs.
  - `flush` in `IDLE` blocks acceptance that cycle.
- NOP or op 7: no effect.

## Timing
- Reset (`resetn` = 0 at an edge): `hi` = `lo` = 0, `busy` = 0, `done` = 0, `div_by_zero` = 0, state `IDLE`. This applies mid-operation as well and discards the operation.
- Let E0 be the accept edge.
- `busy` is registered: high from E0 until the completion edge, when it goes low.
- MULT/MULTU:
  - Completion edge is E0+`MUL_CYCLES`.
  - `hi`/`lo` update at that edge and `done` is high the following cycle.
- DIV/DIVU:
  - Completion edge is E0+`WIDTH`+1: `WIDTH` iteration edges plus the `DIV_FIX` edge.
  - A new operation can be accepted in the cycle after completion (`busy` low).
- Divide by zero: completion edge E0+1.
- `hi`/`lo` are register outputs. An MFHI/MFLO issued the cycle after completion reads the new value.
- Flush and completion at the same edge: flush wins, and there is no write and no `done`.

## Structure
- Package `mdu_pkg`: op encodings (`MDU_NOP` … `MDU_MTLO`) and the state enum.
- Sub-module `mdu_div_core`:
  - Iterative restoring divider with inputs `start`, `dividend`, `divisor` and `abort`.
  - Outputs `quot`, `rem` and `valid`.
  - Unsigned only; sign handling stays in `mdu`.
- The multiplier is an inferred `*`. The `MUL_CYCLES` countdown lives in `mdu`.

## Test plan
- MULT `a`=0xFFFFFFFF, `b`=2 → after 4 cycles `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFE, `done` = 1 for one cycle. MULTU with the same operands → `hi`=0x00000001, `lo`=0xFFFFFFFE.
- DIV −7 ÷ 2 → at E0+33 `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIVU 100 ÷ 7 → `lo`=0x0000000E, `hi`=0x00000002. `busy` is high for exactly 33 cycles.
- DIV 0x80000000 ÷ 0xFFFFFFFF → `lo`=0x80000000, `hi`=0, `div_by_zero`=0.
- DIVU `b`=0 with prior `hi`/`lo`=0x11/0x22 → `done` and `div_by_zero` at E0+1; `hi`/`lo` stay 0x11/0x22.
- Start DIVU, assert `flush` at E0+10 → `busy` drops next cycle, no `done`, HI/LO unchanged. Assert `resetn`=0 mid-MULT → all outputs 0.
- MTHI 0xDEADBEEF then MTLO 0x12345678 on back-to-back cycles → `hi`/`lo` updated each edge, `busy` never high. An `op_valid` MULT issued while a DIV is busy is ignored.
